// File: rtl/a2d_sched.sv
// Conversion scheduler for the A2D SPI path: sequences left/right load-cell reads
// (and a periodic battery read) through the SPI master handshake.
module a2d_sched #(
   parameter int BATT_DIV = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] batt,
   output logic        smpl_vld,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, CMD, WT_CMD, GAP, RD, WT_RD, FIN} state_t;

   localparam logic [3:0] BCNT_MAX = 4'(BATT_DIV - 1);

   state_t      state, nxt_state;
   logic [2:0]  chnl, nxt_chnl;
   logic [3:0]  bcnt;
   logic        do_batt;
   logic        pend;
   logic        unused_hi;

   // The A2D returns a 12-bit result; the upper nibble carries no data.
   assign unused_hi = &rd_data[15:12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chnl  <= 3'd0;
      end else begin
         state <= nxt_state;
         chnl  <= nxt_chnl;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_chnl  = chnl;
      case (state)
         IDLE: begin
            if (nxt || pend) begin
               nxt_state = CMD;
               nxt_chnl  = 3'd0;
            end
         end
         CMD:    nxt_state = WT_CMD;
         WT_CMD: if (done) nxt_state = GAP;
         GAP:    nxt_state = RD;
         RD:     nxt_state = WT_RD;
         WT_RD: begin
            if (done) begin
               case (chnl)
                  3'd0: begin
                     nxt_chnl  = 3'd4;
                     nxt_state = CMD;
                  end
                  3'd4: begin
                     if (do_batt) begin
                        nxt_chnl  = 3'd5;
                        nxt_state = CMD;
                     end else begin
                        nxt_state = FIN;
                     end
                  end
                  default: nxt_state = FIN;
               endcase
            end
         end
         FIN:     nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so wrt/smpl_vld/busy
   // line up with the CMD/RD/FIN cycles themselves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt      <= 1'b0;
         cmd      <= 16'h0000;
         smpl_vld <= 1'b0;
         busy     <= 1'b0;
      end else begin
         wrt      <= (nxt_state == CMD) || (nxt_state == RD);
         smpl_vld <= (nxt_state == FIN);
         busy     <= (nxt_state != IDLE);
         if (nxt_state == CMD)
            cmd <= {2'b00, nxt_chnl, 11'h000};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend    <= 1'b0;
         do_batt <= 1'b0;
         bcnt    <= 4'd0;
      end else begin
         if (state == IDLE) begin
            pend    <= 1'b0;
            do_batt <= (bcnt == 4'd0);
         end else if (nxt) begin
            pend <= 1'b1;
         end
         if (state == FIN)
            bcnt <= (bcnt == BCNT_MAX) ? 4'd0 : bcnt + 4'd1;
      end
   end

   // Battery register resets to full scale so a low-battery check stays quiet
   // until the first real conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_ld  <= 12'h000;
         rght_ld <= 12'h000;
         batt    <= 12'hFFF;
      end else if (state == WT_RD && done) begin
         case (chnl)
            3'd0:    lft_ld  <= rd_data[11:0];
            3'd4:    rght_ld <= rd_data[11:0];
            3'd5:    batt    <= rd_data[11:0];
            default: ;
         endcase
      end
   end

endmodule
